wb_queue: RTL and testbench
===========================

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: entries per per-unit result FIFO (power of two, >=2).
REQ-002 SHALL have parameter STALL_LEVEL, default 2: wbq_stall asserts when any FIFO has <= STALL_LEVEL free entries.
REQ-003 SHALL have port clock  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports am_wb_oper/mul_wb_oper/mem_wb_oper  in  1 each  unit result valid this cycle.
REQ-006 SHALL have ports am_wb_regdest/mul_wb_regdest/mem_wb_regdest  in  5 each  destination register.
REQ-007 SHALL have ports am_wb_writereg/mul_wb_writereg/mem_wb_writereg  in  1 each  result writes a register.
REQ-008 SHALL have ports am_wb_wbvalue/mul_wb_wbvalue/mem_wb_wbvalue  in  32 each  result data.
REQ-009 SHALL have port wb_reg_en  out  1  register-file write enable.
REQ-010 SHALL have port wb_reg_addr  out  5  register-file write address.
REQ-011 SHALL have port wb_reg_data  out  32  register-file write data.
REQ-012 SHALL have port wbq_stall  out  1  request to the issue stage to stop issuing.
REQ-013 SHALL have port wbq_overflow  out  1  sticky: a result was dropped.

Function
REQ-014 SHALL enqueue a unit's {regdest, wbvalue} at the rising edge when its oper=1, writereg=1 and regdest!=0; otherwise the input is discarded.
REQ-015 SHALL hold one FIFO per unit; all three units may enqueue in the same cycle.
REQ-016 SHALL dequeue at most one entry per cycle, chosen round-robin over non-empty FIFOs in order AM->MUL->MEM; the pointer moves to the unit after the one granted.
REQ-017 SHALL drive wb_reg_en/addr/data from registers: entry granted at edge N appears on the outputs after edge N; wb_reg_en=0 when nothing is granted, addr/data then hold their last value.
REQ-018 Without bypass, a result presented in cycle N into an empty FIFO with the grant pointer on it SHALL reach the outputs after edge N+1 (2-cycle latency).
REQ-019 Simultaneous enqueue and dequeue on a full FIFO SHALL be accepted with the count unchanged and SHALL NOT count as overflow.
REQ-020 Enqueue into a full FIFO without a same-cycle dequeue SHALL drop the entry and set wbq_overflow, which stays set until reset.
REQ-021 wbq_stall SHALL be combinational from the FIFO counts: 1 when any FIFO has free entries <= STALL_LEVEL.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH; counts SHALL span 0..DEPTH.
REQ-023 Per-unit order SHALL be preserved; no ordering is guaranteed across units.

Reset
REQ-024 Assertion of reset (low) SHALL immediately empty all FIFOs, clear wb_reg_en, wb_reg_addr, wb_reg_data, wbq_overflow, and return the grant pointer to AM; wbq_stall then reads 0.
REQ-025 Reset asserted mid-operation SHALL discard all queued results; no write occurs on the first edge after release.

Configuration
REQ-026 With WBQ_BYPASS_EN defined, a valid result whose FIFO is empty and which wins arbitration in the same cycle SHALL go straight to the output registers at edge N (1-cycle latency) without entering its FIFO.
REQ-027 Without WBQ_BYPASS_EN, every result SHALL pass through its FIFO (REQ-018 latency).

Structure
REQ-028 Package wb_pkg SHALL hold the unit index constants (UNIT_AM=0, UNIT_MUL=1, UNIT_MEM=2) and the entry typedef wb_entry_t {regdest[4:0], wbvalue[31:0]}.
REQ-029 SHALL instantiate sub-module wb_fifo (parameterized DEPTH, push/pop/full/empty/count) once per unit; arbitration and the output registers stay in wb_queue.

Verification
REQ-030 AM only, regdest=3, value=0x11 at cycle 0 -> wb_reg_en=1, addr=3, data=0x11 after edge 1 (edge 0 with WBQ_BYPASS_EN).
REQ-031 All three units in one cycle (AM r1=1, MUL r2=2, MEM r3=3) -> writes r1, r2, r3 on three consecutive cycles, no gaps.
REQ-032 MUL pushes 5 results back-to-back with DEPTH=4 while AM is continuously busy -> wbq_stall asserts when 2 free, the 5th is dropped only if no pop occurs, wbq_overflow=1.
REQ-033 writereg=0 or regdest=0 with oper=1 -> no enqueue, wb_reg_en stays 0.
REQ-034 Reset pulled low with 3 entries queued -> outputs 0 immediately; after release, no writes occur until new input.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back queue: unit indices and the queued entry format.
package wb_pkg;

    localparam int NUM_UNITS = 3;
    localparam int UNIT_AM   = 0;
    localparam int UNIT_MUL  = 1;
    localparam int UNIT_MEM  = 2;

    typedef logic [1:0] unit_idx_t;

    typedef struct packed {
        logic [4:0]  regdest;
        logic [31:0] wbvalue;
    } wb_entry_t;

    // Round-robin helper: maps an unbounded unit offset back onto 0..NUM_UNITS-1.
    function automatic unit_idx_t unit_wrap(input int u);
        return unit_idx_t'(u % NUM_UNITS);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-unit result FIFO: power-of-two depth, head visible combinationally for the arbiter,
// push into a full FIFO is accepted only when a pop happens in the same cycle.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  wb_entry_t                push_data,
    input  logic                     pop,
    output wb_entry_t                pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_entry_t        mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]    count_reg, count_next;
    logic             do_push, do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    assign pop_data = mem[rd_ptr_reg];
    assign count    = count_reg;

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: three per-unit result FIFOs drained one entry per cycle, round-robin AM->MUL->MEM.
// Optional WBQ_BYPASS_EN lets a result into an empty, granted FIFO go straight to the output registers.
module wb_queue
    import wb_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int STALL_LEVEL = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        am_wb_oper,
    input  logic [4:0]  am_wb_regdest,
    input  logic        am_wb_writereg,
    input  logic [31:0] am_wb_wbvalue,
    input  logic        mul_wb_oper,
    input  logic [4:0]  mul_wb_regdest,
    input  logic        mul_wb_writereg,
    input  logic [31:0] mul_wb_wbvalue,
    input  logic        mem_wb_oper,
    input  logic [4:0]  mem_wb_regdest,
    input  logic        mem_wb_writereg,
    input  logic [31:0] mem_wb_wbvalue,
    output logic        wb_reg_en,
    output logic [4:0]  wb_reg_addr,
    output logic [31:0] wb_reg_data,
    output logic        wbq_stall,
    output logic        wbq_overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [NUM_UNITS-1:0] oper, writereg;
    logic [4:0]           regdest [NUM_UNITS];
    logic [31:0]          wbvalue [NUM_UNITS];

    logic [NUM_UNITS-1:0] in_valid, push, pop, full, empty, req, drop, near_full;
    logic [NUM_UNITS-1:0] grant_vec;
    wb_entry_t            in_entry [NUM_UNITS];
    wb_entry_t            head     [NUM_UNITS];
    logic [CW-1:0]        count    [NUM_UNITS];

    unit_idx_t ptr_reg, ptr_next;
    unit_idx_t grant_idx, cand;
    logic      grant_any;
    wb_entry_t sel_entry;

    logic        en_reg;
    logic [4:0]  addr_reg;
    logic [31:0] data_reg;
    logic        overflow_reg;

    assign oper[UNIT_AM]     = am_wb_oper;
    assign oper[UNIT_MUL]    = mul_wb_oper;
    assign oper[UNIT_MEM]    = mem_wb_oper;
    assign writereg[UNIT_AM]  = am_wb_writereg;
    assign writereg[UNIT_MUL] = mul_wb_writereg;
    assign writereg[UNIT_MEM] = mem_wb_writereg;
    assign regdest[UNIT_AM]  = am_wb_regdest;
    assign regdest[UNIT_MUL] = mul_wb_regdest;
    assign regdest[UNIT_MEM] = mem_wb_regdest;
    assign wbvalue[UNIT_AM]  = am_wb_wbvalue;
    assign wbvalue[UNIT_MUL] = mul_wb_wbvalue;
    assign wbvalue[UNIT_MEM] = mem_wb_wbvalue;

`ifdef WBQ_BYPASS_EN
    logic [NUM_UNITS-1:0] bypass;
`endif

    generate
        for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
            // r0 is hard-wired zero, so a write to it carries no information.
            assign in_valid[gi] = oper[gi] && writereg[gi] && (regdest[gi] != 5'd0);
            assign in_entry[gi] = '{regdest: regdest[gi], wbvalue: wbvalue[gi]};

`ifdef WBQ_BYPASS_EN
            assign req[gi]    = !empty[gi] || in_valid[gi];
            assign bypass[gi] = in_valid[gi] && empty[gi] && grant_vec[gi];
            assign push[gi]   = in_valid[gi] && !bypass[gi];
`else
            assign req[gi]    = !empty[gi];
            assign push[gi]   = in_valid[gi];
`endif
            assign pop[gi]       = grant_vec[gi] && !empty[gi];
            assign drop[gi]      = push[gi] && full[gi] && !pop[gi];
            assign near_full[gi] = (int'(count[gi]) + STALL_LEVEL) >= DEPTH;

            wb_fifo #(
                .DEPTH (DEPTH)
            ) u_fifo (
                .clock     (clock),
                .reset     (reset),
                .push      (push[gi]),
                .push_data (in_entry[gi]),
                .pop       (pop[gi]),
                .pop_data  (head[gi]),
                .full      (full[gi]),
                .empty     (empty[gi]),
                .count     (count[gi])
            );
        end
    endgenerate

    // First requester at or after the pointer wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = ptr_reg;
        cand      = ptr_reg;
        grant_vec = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            cand = unit_wrap(int'(ptr_reg) + i);
            if (!grant_any && req[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        for (int i = 0; i < NUM_UNITS; i++) begin
            grant_vec[i] = grant_any && (grant_idx == unit_idx_t'(i));
        end
        ptr_next = grant_any ? unit_wrap(int'(grant_idx) + 1) : ptr_reg;
    end

    always_comb begin
        sel_entry = head[grant_idx];
`ifdef WBQ_BYPASS_EN
        if (empty[grant_idx]) begin
            sel_entry = in_entry[grant_idx];
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_reg      <= unit_idx_t'(UNIT_AM);
            en_reg       <= 1'b0;
            addr_reg     <= '0;
            data_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
            en_reg  <= grant_any;
            if (grant_any) begin
                addr_reg <= sel_entry.regdest;
                data_reg <= sel_entry.wbvalue;
            end
            overflow_reg <= overflow_reg || (|drop);
        end
    end

    assign wb_reg_en    = en_reg;
    assign wb_reg_addr  = addr_reg;
    assign wb_reg_data  = data_reg;
    assign wbq_overflow = overflow_reg;
    assign wbq_stall    = |near_full;

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed scenarios plus random traffic against a queue-based model.
module tb_wb_queue;

    localparam int DEPTH       = 4;
    localparam int STALL_LEVEL = 2;
`ifdef WBQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        op [3];
    logic        wr [3];
    logic [4:0]  rd [3];
    logic [31:0] vl [3];

    logic        wb_reg_en, wbq_stall, wbq_overflow;
    logic [4:0]  wb_reg_addr;
    logic [31:0] wb_reg_data;

    wb_queue #(.DEPTH(DEPTH), .STALL_LEVEL(STALL_LEVEL)) dut (
        .clock           (clock),
        .reset           (reset),
        .am_wb_oper      (op[0]),
        .am_wb_regdest   (rd[0]),
        .am_wb_writereg  (wr[0]),
        .am_wb_wbvalue   (vl[0]),
        .mul_wb_oper     (op[1]),
        .mul_wb_regdest  (rd[1]),
        .mul_wb_writereg (wr[1]),
        .mul_wb_wbvalue  (vl[1]),
        .mem_wb_oper     (op[2]),
        .mem_wb_regdest  (rd[2]),
        .mem_wb_writereg (wr[2]),
        .mem_wb_wbvalue  (vl[2]),
        .wb_reg_en       (wb_reg_en),
        .wb_reg_addr     (wb_reg_addr),
        .wb_reg_data     (wb_reg_data),
        .wbq_stall       (wbq_stall),
        .wbq_overflow    (wbq_overflow)
    );

    // Reference model state
    ent_t        q [3][$];
    int          m_ptr;
    logic        m_en, m_ovf;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int u = 0; u < 3; u++) q[u].delete();
        m_ptr  = 0;
        m_en   = 1'b0;
        m_addr = '0;
        m_data = '0;
        m_ovf  = 1'b0;
    endtask

    function automatic bit valid_in(input int u);
        return op[u] && wr[u] && (rd[u] != 5'd0);
    endfunction

    function automatic logic m_stall();
        for (int u = 0; u < 3; u++)
            if (DEPTH - q[u].size() <= STALL_LEVEL) return 1'b1;
        return 1'b0;
    endfunction

    // One clock edge of the queue as described behaviourally: grant, then enqueue.
    task automatic model_edge();
        int g;
        bit bypassed [3];
        ent_t e;
        g = -1;
        for (int u = 0; u < 3; u++) bypassed[u] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            int u;
            u = (m_ptr + i) % 3;
            if (g < 0 && (q[u].size() > 0 || (BYP && valid_in(u)))) g = u;
        end
        if (g >= 0) begin
            if (q[g].size() == 0) begin
                e.a = rd[g];
                e.d = vl[g];
                bypassed[g] = 1'b1;
            end else begin
                e = q[g].pop_front();
            end
            m_en   = 1'b1;
            m_addr = e.a;
            m_data = e.d;
            m_ptr  = (g + 1) % 3;
        end else begin
            m_en = 1'b0;
        end
        for (int u = 0; u < 3; u++) begin
            if (valid_in(u) && !bypassed[u]) begin
                if (q[u].size() < DEPTH) q[u].push_back('{a: rd[u], d: vl[u]});
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        string t;
        t = $sformatf("%s c%0d", tag, cyc);
        chk({t, " en"},    32'(wb_reg_en),    32'(m_en));
        chk({t, " addr"},  32'(wb_reg_addr),  32'(m_addr));
        chk({t, " data"},  wb_reg_data,       m_data);
        chk({t, " stall"}, 32'(wbq_stall),    32'(m_stall()));
        chk({t, " ovf"},   32'(wbq_overflow), 32'(m_ovf));
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        cyc++;
        check_all(tag);
        if (wb_reg_en === 1'b1)
            $display("c%0d %s write r%0d = %08h", cyc, tag, wb_reg_addr, wb_reg_data);
    endtask

    task automatic set_in(input int u, input logic o, input logic w,
                          input logic [4:0] r, input logic [31:0] v);
        op[u] = o; wr[u] = w; rd[u] = r; vl[u] = v;
    endtask

    task automatic idle_in();
        for (int u = 0; u < 3; u++) set_in(u, 1'b0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        idle_in();
        model_reset();
        #22;
        check_all("reset");
        reset = 1'b1;

        // Single AM result
        set_in(0, 1'b1, 1'b1, 5'd3, 32'h11);
        step("am_single");
        idle_in();
        repeat (3) step("am_drain");

        // All three units in one cycle
        set_in(0, 1'b1, 1'b1, 5'd1, 32'hA1);
        set_in(1, 1'b1, 1'b1, 5'd2, 32'hB2);
        set_in(2, 1'b1, 1'b1, 5'd3, 32'hC3);
        step("all3");
        idle_in();
        repeat (4) step("all3_drain");

        // Discarded inputs
        set_in(0, 1'b1, 1'b0, 5'd7, 32'hDEAD);
        set_in(1, 1'b1, 1'b1, 5'd0, 32'hBEEF);
        step("discard");
        idle_in();
        repeat (2) step("discard_idle");

        // MUL bursts while AM and MEM stay busy, forcing stall and overflow
        for (int i = 0; i < 6; i++) begin
            set_in(0, 1'b1, 1'b1, 5'd10, 32'h1000 + 32'(i));
            set_in(1, 1'b1, 1'b1, 5'd11, 32'h2000 + 32'(i));
            set_in(2, 1'b1, 1'b1, 5'd12, 32'h3000 + 32'(i));
            step("burst");
        end
        idle_in();
        repeat (14) step("burst_drain");

        // Reset mid-operation with entries queued
        set_in(0, 1'b1, 1'b1, 5'd4, 32'h44);
        set_in(1, 1'b1, 1'b1, 5'd5, 32'h55);
        set_in(2, 1'b1, 1'b1, 5'd6, 32'h66);
        step("prefill");
        idle_in();
        #3 reset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #2 reset = 1'b1;
        repeat (3) step("post_rst");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            for (int u = 0; u < 3; u++)
                set_in(u, ($urandom_range(0, 99) < 45), ($urandom_range(0, 9) != 0),
                       5'($urandom_range(0, 31)), $urandom());
            step("rand");
        end
        idle_in();
        repeat (15) step("rand_drain");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
